id_ex_ctrl: RTL

Decode-stage controller for the RV32I pipeline. It decodes the ID-stage instruction, drives `EXTOp` to the immediate extender, and detects load-use hazards to stall IF/ID and insert bubbles. It also applies branch/jump flushes from EX and owns the ID/EX control pipeline register plus stall/flush event counters. It sits between the IF/ID register and the EX stage; the register file, immediate extender and ALU decode hang off its outputs.

---
 rtl/id_ex_ctrl_pkg.sv | 47 ++++
 rtl/id_ex_ctrl_if.sv | 43 ++++
 rtl/id_ex_ctrl_decode.sv | 100 ++++++++++
 rtl/id_ex_ctrl.sv | 100 ++++++++++
 4 files changed

// File: rtl/id_ex_ctrl_pkg.sv
// Shared decode constants for the ID/EX control slice: EXTOp one-hot codes,
// RV32I major opcodes, writeback select codes and the EX control bundle.
package id_ex_ctrl_pkg;

  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_I     = 6'b010000;
  localparam logic [5:0] EXT_S     = 6'b001000;
  localparam logic [5:0] EXT_B     = 6'b000100;
  localparam logic [5:0] EXT_U     = 6'b000010;
  localparam logic [5:0] EXT_J     = 6'b000001;
  localparam logic [5:0] EXT_NONE  = 6'b000000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       alusrc_imm;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [1:0] wdsel;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [5:0] extop;
  } ctrl_t;

  // A bubble is the all-zero bundle, index fields included.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_ctrl_if.sv
// ID-side handshake and EX-side control bus of the decode controller.
interface id_ex_ctrl_if #(parameter int CNT_W = 16);
  logic             id_valid;
  logic [31:0]      instr_id;
  logic             ex_flush;
  logic [5:0]       EXTOp;
  logic             stall_if;
  logic             flush_if_id;
  logic             ex_valid;
  logic [4:0]       ex_rd;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic             ex_regwrite;
  logic             ex_memread;
  logic             ex_memwrite;
  logic             ex_alusrc_imm;
  logic             ex_branch;
  logic             ex_jump;
  logic             ex_jalr;
  logic [1:0]       ex_wdsel;
  logic [2:0]       ex_funct3;
  logic             ex_funct7b5;
  logic [5:0]       ex_extop;
  logic             illegal;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, instr_id, ex_flush,
    input  EXTOp, stall_if, flush_if_id, ex_valid, ex_rd, ex_rs1, ex_rs2,
           ex_regwrite, ex_memread, ex_memwrite, ex_alusrc_imm, ex_branch,
           ex_jump, ex_jalr, ex_wdsel, ex_funct3, ex_funct7b5, ex_extop,
           illegal, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, instr_id, ex_flush,
    output EXTOp, stall_if, flush_if_id, ex_valid, ex_rd, ex_rs1, ex_rs2,
           ex_regwrite, ex_memread, ex_memwrite, ex_alusrc_imm, ex_branch,
           ex_jump, ex_jalr, ex_wdsel, ex_funct3, ex_funct7b5, ex_extop,
           illegal, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_ctrl_decode.sv
// Purely combinational RV32I decode: immediate select, source-register usage
// and the EX control bundle. Unknown opcodes decode to an all-zero bundle.
module id_decode
  import id_ex_ctrl_pkg::*;
(
  input  logic        id_valid_i,
  input  logic [31:0] instr_i,
  output logic [5:0]  extop_o,
  output logic        rs1_used_o,
  output logic        rs2_used_o,
  output logic        legal_o,
  output ctrl_t       ctrl_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       unused_bits;

  assign opc         = instr_i[6:0];
  assign f3          = instr_i[14:12];
  assign unused_bits = ^{instr_i[31], instr_i[29:25]};

  // Opcode table to controls; index fields only filled for known opcodes.
  always_comb begin
    ctrl_o     = CTRL_BUBBLE;
    legal_o    = 1'b1;
    rs1_used_o = 1'b1;
    rs2_used_o = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        ctrl_o.extop      = EXT_U;
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.alusrc_imm = 1'b1;
        rs1_used_o        = 1'b0;
      end
      OPC_JAL: begin
        ctrl_o.extop    = EXT_J;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.jump     = 1'b1;
        ctrl_o.wdsel    = WD_PC4;
        rs1_used_o      = 1'b0;
      end
      OPC_JALR: begin
        ctrl_o.extop      = EXT_I;
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.jalr       = 1'b1;
        ctrl_o.alusrc_imm = 1'b1;
        ctrl_o.wdsel      = WD_PC4;
      end
      OPC_BRANCH: begin
        ctrl_o.extop  = EXT_B;
        ctrl_o.branch = 1'b1;
        rs2_used_o    = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_o.extop      = EXT_I;
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.memread    = 1'b1;
        ctrl_o.alusrc_imm = 1'b1;
        ctrl_o.wdsel      = WD_MEM;
      end
      OPC_STORE: begin
        ctrl_o.extop      = EXT_S;
        ctrl_o.memwrite   = 1'b1;
        ctrl_o.alusrc_imm = 1'b1;
        rs2_used_o        = 1'b1;
      end
      OPC_OPIMM: begin
        ctrl_o.extop      = (f3 == 3'b001 || f3 == 3'b101) ? EXT_SHAMT : EXT_I;
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.alusrc_imm = 1'b1;
      end
      OPC_OP: begin
        ctrl_o.extop    = EXT_NONE;
        ctrl_o.regwrite = 1'b1;
        rs2_used_o      = 1'b1;
      end
      default: begin
        legal_o    = 1'b0;
        rs1_used_o = 1'b0;
      end
    endcase
    if (legal_o) begin
      ctrl_o.rd       = instr_i[11:7];
      ctrl_o.rs1      = instr_i[19:15];
      ctrl_o.rs2      = instr_i[24:20];
      ctrl_o.funct3   = f3;
      ctrl_o.funct7b5 = instr_i[30];
      // Writes to x0 are architecturally dropped; keep them off the bypass net.
      if (instr_i[11:7] == 5'd0) ctrl_o.regwrite = 1'b0;
    end
  end

  // The extender sees nothing while IF/ID is empty.
  always_comb begin
    extop_o = id_valid_i ? ctrl_o.extop : EXT_NONE;
  end

endmodule

// File: rtl/id_ex_ctrl.sv
// ID-stage controller: load-use hazard detection, EX flush handling, the
// ID/EX control register and saturating stall/flush event counters.
module id_ex_ctrl
  import id_ex_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rstn,
  id_ex_ctrl_if.slave bus
);

  logic             rs1_used;
  logic             rs2_used;
  logic             legal;
  ctrl_t            dec;
  logic             hz;

  ctrl_t            ex_q, ex_d;
  logic             ex_valid_q, ex_valid_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  id_decode u_decode (
    .id_valid_i (bus.id_valid),
    .instr_i    (bus.instr_id),
    .extop_o    (bus.EXTOp),
    .rs1_used_o (rs1_used),
    .rs2_used_o (rs2_used),
    .legal_o    (legal),
    .ctrl_o     (dec)
  );

  // Load-use hazard against the instruction currently in EX.
  always_comb begin
    hz = bus.id_valid & ex_valid_q & ex_q.memread & (ex_q.rd != 5'd0) &
         ((rs1_used & (bus.instr_id[19:15] == ex_q.rd)) |
          (rs2_used & (bus.instr_id[24:20] == ex_q.rd)));
  end

  assign bus.stall_if    = hz & ~bus.ex_flush;
  assign bus.flush_if_id = bus.ex_flush;

  // Next EX contents: flush beats stall beats normal issue.
  always_comb begin
    ex_d        = CTRL_BUBBLE;
    ex_valid_d  = 1'b0;
    illegal_d   = 1'b0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.ex_flush) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (hz) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end else if (bus.id_valid && legal) begin
      ex_d       = dec;
      ex_valid_d = 1'b1;
    end else if (bus.id_valid) begin
      illegal_d = 1'b1;
    end
  end

  // ID/EX pipeline register and counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_q        <= CTRL_BUBBLE;
      ex_valid_q  <= 1'b0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      ex_valid_q  <= ex_valid_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_rs1        = ex_q.rs1;
  assign bus.ex_rs2        = ex_q.rs2;
  assign bus.ex_regwrite   = ex_q.regwrite;
  assign bus.ex_memread    = ex_q.memread;
  assign bus.ex_memwrite   = ex_q.memwrite;
  assign bus.ex_alusrc_imm = ex_q.alusrc_imm;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_jump       = ex_q.jump;
  assign bus.ex_jalr       = ex_q.jalr;
  assign bus.ex_wdsel      = ex_q.wdsel;
  assign bus.ex_funct3     = ex_q.funct3;
  assign bus.ex_funct7b5   = ex_q.funct7b5;
  assign bus.ex_extop      = ex_q.extop;
  assign bus.illegal       = illegal_q;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.flush_cnt     = flush_cnt_q;

endmodule
